// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 6-digit seven-segment scanner for PC byte and write-back halfword.
module seg_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic [7:0]  pc_val,
  input  logic [15:0] wb_val,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        dp
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [CW-1:0] scanCnt;
  logic [2:0]    digitIdx;
  logic [7:0]    shadowPc;
  logic [15:0]   shadowWb;
  logic [3:0]    nibble;
  logic          blankDigit;
  logic          deadTime;
  logic          wrap;
  assign wrap     = scanCnt == CW'(SCAN_DIV - 1);
  assign deadTime = int'(scanCnt) < DEAD;
  assign nibble = digitIdx == 3'd0 ? shadowPc[7:4]   :
                  digitIdx == 3'd1 ? shadowPc[3:0]   :
                  digitIdx == 3'd2 ? shadowWb[15:12] :
                  digitIdx == 3'd3 ? shadowWb[11:8]  :
                  digitIdx == 3'd4 ? shadowWb[7:4]   : shadowWb[3:0];
  // Blanking looks at every more-significant nibble of the same group
  assign blankDigit = (BLANK_LZ != 0) && (
                      digitIdx == 3'd0 ? shadowPc[7:4] == 4'h0    :
                      digitIdx == 3'd2 ? shadowWb[15:12] == 4'h0  :
                      digitIdx == 3'd3 ? shadowWb[15:8] == 8'h00  :
                      digitIdx == 3'd4 ? shadowWb[15:4] == 12'h000 : 1'b0);
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadowPc <= '0;
      shadowWb <= '0;
      scanCnt  <= '0;
      digitIdx <= '0;
    end else begin
      if (load && !hold) begin
        shadowPc <= pc_val;
        shadowWb <= wb_val;
      end
      scanCnt <= wrap ? '0 : scanCnt + 1'b1;
      if (wrap) digitIdx <= digitIdx == 3'd5 ? 3'd0 : digitIdx + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= '1;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= deadTime ? 6'b111111 : ~(6'b000001 << digitIdx);
      seg <= (deadTime || blankDigit) ? 7'b1111111 : HEX[nibble];
      dp  <= deadTime || digitIdx != 3'd1;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan order, decoding, blanking, hold and reset.
module tb_seg_scan_display;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  pcVal = '0;
  logic [15:0] wbVal = '0;
  logic [6:0]  seg0, seg1;
  logic [5:0]  an0, an1;
  logic        dp0, dp1;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  // u0 never blanks, u1 blanks leading zeros; both scan 4 clocks per digit with 1 dead clock
  seg_scan_display #(.SCAN_DIV(4), .DEAD(1), .BLANK_LZ(0)) u0 (
    .clk(clk), .rst(rst), .load(load), .hold(hold), .pc_val(pcVal), .wb_val(wbVal),
    .seg(seg0), .an(an0), .dp(dp0));
  seg_scan_display #(.SCAN_DIV(4), .DEAD(1), .BLANK_LZ(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .hold(hold), .pc_val(pcVal), .wb_val(wbVal),
    .seg(seg1), .an(an1), .dp(dp1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then load on the first active edge; afterwards the first slot is digit0
  task automatic restart(input logic [7:0] pc, input logic [15:0] wb);
    rst = 1'b0; load = 1'b0; hold = 1'b0;
    step();
    rst = 1'b1; load = 1'b1; pcVal = pc; wbVal = wb;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; pcVal = 8'hA5; wbVal = 16'h5AC3;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (an0 !== 6'b111111 || seg0 !== 7'b1111111 || dp0 !== 1'b1 || an1 !== 6'b111111 || seg1 !== 7'b1111111) begin
        $display("FAIL reset_hold_%0d: an=%b seg=%b dp=%b an1=%b seg1=%b required an=111111 seg=1111111 dp=1", i, an0, seg0, dp0, an1, seg1);
      end else passed++;
    end
    rst = 1'b1; load = 1'b0;
    step();
    total++;
    if (an0 !== 6'b111111 || seg0 !== 7'b1111111) begin
      $display("FAIL reset_first_dead: an=%b seg=%b required an=111111 seg=1111111", an0, seg0);
    end else passed++;
    step();
    total++;
    if (an0 !== 6'b111110 || seg0 !== 7'b1000000 || seg1 !== 7'b1111111 || dp0 !== 1'b1) begin
      $display("FAIL reset_digit0: an=%b seg=%b seg1=%b dp=%b required an=111110 seg=1000000 seg1=1111111 dp=1", an0, seg0, seg1, dp0);
    end else passed++;
  endtask

  task automatic test_scan_order();
    logic [5:0] exp;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step();
      exp = (i % 4 == 0) ? 6'b111111 : ~(6'b000001 << ((i / 4) % 6));
      total++;
      if (an0 !== exp || an1 !== exp) begin
        $display("FAIL scan_edge_%0d: an=%b an1=%b required %b", i + 1, an0, an1, exp);
      end else passed++;
    end
  endtask

  task automatic test_digits(input string name, input logic [7:0] pc, input logic [15:0] wb,
                             input logic [0:5][6:0] e0, input logic [0:5][6:0] e1);
    logic [5:0] expAn;
    restart(pc, wb);
    for (int s = 0; s < 6; s++) begin
      step();
      expAn = ~(6'b000001 << s);
      total++;
      if (an0 !== expAn || an1 !== expAn || seg0 !== e0[s] || seg1 !== e1[s] || dp0 !== (s != 1)) begin
        $display("FAIL %s_digit%0d: an=%b an1=%b seg=%b seg1=%b dp=%b required an=%b seg=%b seg1=%b dp=%b",
                 name, s, an0, an1, seg0, seg1, dp0, expAn, e0[s], e1[s], s != 1);
      end else passed++;
      for (int k = 0; k < 3; k++) step();
      total++;
      if (an0 !== 6'b111111 || seg0 !== 7'b1111111 || dp0 !== 1'b1) begin
        $display("FAIL %s_dead%0d: an=%b seg=%b dp=%b required an=111111 seg=1111111 dp=1", name, s, an0, seg0, dp0);
      end else passed++;
    end
  endtask

  task automatic test_hold();
    restart(8'h12, 16'h3456);
    hold = 1'b1; load = 1'b1; pcVal = 8'hFF; wbVal = 16'hFFFF;
    for (int s = 0; s < 6; s++) begin
      logic [0:5][6:0] e;
      e = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
      step();
      total++;
      if (seg0 !== e[s] || seg1 !== e[s] || an0 !== ~(6'b000001 << s)) begin
        $display("FAIL hold_digit%0d: seg=%b seg1=%b an=%b required seg=%b", s, seg0, seg1, an0, e[s]);
      end else passed++;
      for (int k = 0; k < 3; k++) step();
    end
    hold = 1'b0;
    step();
    total++;
    if (seg0 !== 7'b1111001 || an0 !== 6'b111110) begin
      $display("FAIL hold_release_stale: seg=%b an=%b required seg=1111001 an=111110", seg0, an0);
    end else passed++;
    load = 1'b0;
    step();
    total++;
    if (seg0 !== 7'b0001110 || seg1 !== 7'b0001110) begin
      $display("FAIL hold_release_new: seg=%b seg1=%b required 0001110", seg0, seg1);
    end else passed++;
    for (int k = 0; k < 4; k++) step();
    total++;
    if (seg0 !== 7'b0001110 || an0 !== 6'b111101 || dp0 !== 1'b0) begin
      $display("FAIL hold_release_digit1: seg=%b an=%b dp=%b required seg=0001110 an=111101 dp=0", seg0, an0, dp0);
    end else passed++;
  endtask

  task automatic test_reset_mid_scan();
    restart(8'h9A, 16'hBCDE);
    for (int k = 0; k < 17; k++) step();
    total++;
    if (an0 !== 6'b101111 || seg0 !== 7'b0100001) begin
      $display("FAIL midscan_before: an=%b seg=%b required an=101111 seg=0100001", an0, seg0);
    end else passed++;
    rst = 1'b0;
    step();
    total++;
    if (an0 !== 6'b111111 || seg0 !== 7'b1111111 || dp0 !== 1'b1 || an1 !== 6'b111111) begin
      $display("FAIL midscan_reset: an=%b seg=%b dp=%b an1=%b required an=111111 seg=1111111 dp=1", an0, seg0, dp0, an1);
    end else passed++;
    rst = 1'b1;
    step();
    total++;
    if (an0 !== 6'b111111) begin
      $display("FAIL midscan_dead: an=%b required 111111", an0);
    end else passed++;
    step();
    total++;
    if (an0 !== 6'b111110 || seg0 !== 7'b1000000 || seg1 !== 7'b1111111) begin
      $display("FAIL midscan_digit0: an=%b seg=%b seg1=%b required an=111110 seg=1000000 seg1=1111111", an0, seg0, seg1);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_digits("values", 8'h3C, 16'h00A7,
      {7'b0110000, 7'b1000110, 7'b1000000, 7'b1000000, 7'b0001000, 7'b1111000},
      {7'b0110000, 7'b1000110, 7'b1111111, 7'b1111111, 7'b0001000, 7'b1111000});
    test_digits("blanking", 8'h05, 16'h0000,
      {7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
      {7'b1111111, 7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
    test_hold();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
